ps2_rx_fifo: RTL and testbench
==============================

Name: ps2_rx_fifo

Overview:
Parametrised PS/2 keyboard receiver for the Flounder CPLD. It replaces the single-register scan-code latch with a complete frame checker: start, odd parity and stop bits, plus an inter-bit timeout. Good scan codes are buffered in a FIFO, and the block exposes a data/status register pair to the Z180 I/O read path. The address decoder drives CS_N for the I/O 0x4000 window; ADDR selects the data or status register.

Parameters:
FIFO_DEPTH, 8, scan-code entries; power of two, minimum 2.
SAMPLE_DELAY, 8, CLK cycles after a synced KB_CLK falling edge before KB_DATA is sampled; minimum 1.
TIMEOUT_CYCLES, 4096, CLK cycles with no new sample, mid-frame, before the frame is aborted.

Ports:
CLK  in  1  system clock
RST  in  1  synchronous reset, active-low
KB_CLK  in  1  PS/2 clock, asynchronous
KB_DATA  in  1  PS/2 data, asynchronous
CS_N  in  1  block select from I/O decode, active-low
RD_N  in  1  CPU read strobe, active-low
ADDR  in  1  0 = data register, 1 = status register
DOUT  out  8  read data
DOE  out  1  high when CS_N=0 and RD_N=0; top level tri-states D with it
IRQ  out  1  high while FIFO is not empty

Behaviour:
- Reset (RST=0 at a CLK edge):
  - FIFO is emptied and all pointers and counts are cleared.
  - FSM goes to IDLE; sticky flags, DOUT and IRQ are 0.
  - Synchronisers preset to 1.
  - A frame in progress is discarded; reception resumes at the next start bit after RST=1.
- Synchronisation and sampling:
  - KB_CLK and KB_DATA each pass through 2 flops.
  - A falling edge of synced KB_CLK starts the delay counter.
  - After SAMPLE_DELAY cycles with synced KB_CLK still low, synced KB_DATA is sampled once.
  - If KB_CLK returns high before the delay expires, no sample is taken (glitch ignored).
- FSM states IDLE, DATA, PARITY, STOP. Transitions occur only on a sample.
  - IDLE: sample 0 -> DATA with bit count 0. Sample 1 -> stay in IDLE (false start).
  - DATA: shift the sample in, LSB first. After the 8th bit -> PARITY.
  - PARITY: store the sample -> STOP.
  - STOP:
    - Sample 1 and odd parity over data+parity -> push the byte, then go to IDLE.
    - Parity fails -> set PERR, drop the byte.
    - Stop bit = 0 -> set FERR, drop the byte.
    - In every case return to IDLE.
- Timeout:
  - In any state other than IDLE, a counter counts CLK cycles since the last sample.
  - Reaching TIMEOUT_CYCLES -> set FERR, return to IDLE, no push.
  - Counter clears on every sample.
- FIFO:
  - Push when full -> byte dropped, OVF set; contents unchanged.
  - Pop and push in the same cycle while full -> both happen, no OVF, count unchanged.
  - Pop when empty -> no effect.
  - Count width is clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
- Read interface:
  - DOUT is registered and updated every cycle.
  - ADDR=0: DOUT = FIFO head, or 0x00 when empty.
  - ADDR=1: DOUT = {3'b000, FERR, PERR, OVF, FULL, NOT_EMPTY}.
  - A read access ends on the rising edge of synced (CS_N|RD_N), i.e. when CS_N or RD_N deasserts.
  - Data read ending -> one pop.
  - Status read ending -> clears FERR, PERR and OVF. A flag-setting event in that same cycle wins.
  - A held strobe never pops more than once.
- IRQ = NOT_EMPTY, combinational from the count.

Test Plan:
- Valid frame carrying 0x1C (start 0, data LSB first, parity 0, stop 1) -> status 0x01, IRQ=1; data read returns 0x1C; status then reads 0x00 and IRQ=0.
- Frame 0x1C with the parity bit forced to 1 -> no push; status 0x08; a second status read returns 0x00.
- 9 valid frames 0x01..0x09 with FIFO_DEPTH=8, no reads -> status 0x07. Eight data reads return 0x01..0x08 in order; a ninth returns 0x00.
- Frame stops after 4 data bits with TIMEOUT_CYCLES=64 -> FERR set about 64 cycles after the last sample. A following valid 0x5A frame is received correctly.
- RST=0 asserted mid-frame, then RST=1, then a valid 0x29 frame -> only 0x29 is in the FIFO, all flags are 0. A glitch low pulse shorter than SAMPLE_DELAY on KB_CLK is ignored.
- FIFO full, a data read ends in the same cycle as a frame push -> count stays 8, OVF=0, the new byte appears after the 7 older entries.

Source files
------------

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver with full frame checking and a scan-code FIFO.
// Frames are checked for start, odd parity and stop bits, and are aborted
// if the keyboard goes quiet mid-frame. Good bytes are queued.
// The CPU sees a data register (FIFO head) and a status register.
module ps2_rx_fifo #(
    parameter int FIFO_DEPTH     = 8,
    parameter int SAMPLE_DELAY   = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       KB_CLK,
    input  logic       KB_DATA,
    input  logic       CS_N,
    input  logic       RD_N,
    input  logic       ADDR,
    output logic [7:0] DOUT,
    output logic       DOE,
    output logic       IRQ
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int DLY_W = $clog2(SAMPLE_DELAY + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_t;

    // True when data plus parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        odd_parity_ok = ^{data, par};
    endfunction

    // ------------------------------------------------------------------
    // Synchronisers and edge detectors
    // ------------------------------------------------------------------
    logic kbc_meta_r, kbc_sync_r, kbc_prev_r;
    logic kbd_meta_r, kbd_sync_r;
    logic strb_meta_r, strb_sync_r, strb_prev_r;
    logic addr_meta_r, addr_sync_r;
    logic rd_addr_r;

    logic fall_s;
    logic rd_end_s;

    // Double-flop every asynchronous input; all preset to idle-high.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            kbc_meta_r  <= 1'b1;
            kbc_sync_r  <= 1'b1;
            kbc_prev_r  <= 1'b1;
            kbd_meta_r  <= 1'b1;
            kbd_sync_r  <= 1'b1;
            strb_meta_r <= 1'b1;
            strb_sync_r <= 1'b1;
            strb_prev_r <= 1'b1;
            addr_meta_r <= 1'b1;
            addr_sync_r <= 1'b1;
        end else begin
            kbc_meta_r  <= KB_CLK;
            kbc_sync_r  <= kbc_meta_r;
            kbc_prev_r  <= kbc_sync_r;
            kbd_meta_r  <= KB_DATA;
            kbd_sync_r  <= kbd_meta_r;
            strb_meta_r <= CS_N | RD_N;
            strb_sync_r <= strb_meta_r;
            strb_prev_r <= strb_sync_r;
            addr_meta_r <= ADDR;
            addr_sync_r <= addr_meta_r;
        end
    end

    // Remember which register the access targets while the strobe is active,
    // so the end-of-access action does not depend on ADDR after deassertion.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            rd_addr_r <= 1'b0;
        end else if (!strb_sync_r) begin
            rd_addr_r <= addr_sync_r;
        end else begin
            rd_addr_r <= rd_addr_r;
        end
    end

    assign fall_s   = kbc_prev_r & ~kbc_sync_r;
    assign rd_end_s = strb_sync_r & ~strb_prev_r;

    // ------------------------------------------------------------------
    // Sample point generation
    // ------------------------------------------------------------------
    logic             dly_active_r;
    logic [DLY_W-1:0] dly_cnt_r;
    logic             sample_s;

    assign sample_s = dly_active_r & ~kbc_sync_r
                    & (dly_cnt_r == DLY_W'(SAMPLE_DELAY - 1));

    // Count the settle delay after a KB_CLK fall; a rising KB_CLK cancels it.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            dly_active_r <= 1'b0;
            dly_cnt_r    <= '0;
        end else if (fall_s) begin
            dly_active_r <= 1'b1;
            dly_cnt_r    <= '0;
        end else if (dly_active_r) begin
            if (kbc_sync_r || sample_s) begin
                dly_active_r <= 1'b0;
                dly_cnt_r    <= '0;
            end else begin
                dly_active_r <= 1'b1;
                dly_cnt_r    <= dly_cnt_r + DLY_W'(1);
            end
        end else begin
            dly_active_r <= 1'b0;
            dly_cnt_r    <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM and inter-bit timeout
    // ------------------------------------------------------------------
    rx_state_t        state_r, state_nxt_s;
    logic [7:0]       shreg_r, shreg_nxt_s;
    logic [2:0]       bitcnt_r, bitcnt_nxt_s;
    logic             par_r, par_nxt_s;
    logic [TO_W-1:0]  to_cnt_r;
    logic             timeout_s;
    logic             push_s;
    logic             perr_set_s;
    logic             ferr_set_s;

    assign timeout_s = (state_r != ST_IDLE) & ~sample_s
                     & (to_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));

    // Cycles since the last sample while a frame is open.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            to_cnt_r <= '0;
        end else if (state_r == ST_IDLE || sample_s || timeout_s) begin
            to_cnt_r <= '0;
        end else begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
        end
    end

    // FSM state and receive datapath registers.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_r  <= ST_IDLE;
            shreg_r  <= 8'h00;
            bitcnt_r <= 3'd0;
            par_r    <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            shreg_r  <= shreg_nxt_s;
            bitcnt_r <= bitcnt_nxt_s;
            par_r    <= par_nxt_s;
        end
    end

    // Next-state logic; the FSM only moves on a sample or on a timeout.
    always_comb begin
        state_nxt_s  = state_r;
        shreg_nxt_s  = shreg_r;
        bitcnt_nxt_s = bitcnt_r;
        par_nxt_s    = par_r;
        push_s       = 1'b0;
        perr_set_s   = 1'b0;
        ferr_set_s   = 1'b0;
        if (timeout_s) begin
            state_nxt_s = ST_IDLE;
            ferr_set_s  = 1'b1;
        end else if (sample_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (!kbd_sync_r) begin
                        state_nxt_s  = ST_DATA;
                        bitcnt_nxt_s = 3'd0;
                    end else begin
                        state_nxt_s  = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    shreg_nxt_s = {kbd_sync_r, shreg_r[7:1]};
                    if (bitcnt_r == 3'd7) begin
                        state_nxt_s = ST_PARITY;
                    end else begin
                        bitcnt_nxt_s = bitcnt_r + 3'd1;
                    end
                end
                ST_PARITY: begin
                    par_nxt_s   = kbd_sync_r;
                    state_nxt_s = ST_STOP;
                end
                ST_STOP: begin
                    ferr_set_s  = ~kbd_sync_r;
                    perr_set_s  = ~odd_parity_ok(shreg_r, par_r);
                    push_s      = kbd_sync_r & odd_parity_ok(shreg_r, par_r);
                    state_nxt_s = ST_IDLE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // ------------------------------------------------------------------
    // Scan-code FIFO
    // ------------------------------------------------------------------
    logic [7:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             empty_s, full_s;
    logic             pop_s, push_do_s, ovf_set_s, st_clr_s;

    assign empty_s   = (count_r == CNT_W'(0));
    assign full_s    = (count_r == CNT_W'(FIFO_DEPTH));
    assign pop_s     = rd_end_s & ~rd_addr_r & ~empty_s;
    assign st_clr_s  = rd_end_s & rd_addr_r;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_do_s = push_s & (~full_s | pop_s);
    assign ovf_set_s = push_s & full_s & ~pop_s;

    // Storage array; contents are don't-care while the count says empty.
    always_ff @(posedge CLK) begin
        if (push_do_s) begin
            mem_r[wr_ptr_r] <= shreg_r;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_do_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_do_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags and read interface
    // ------------------------------------------------------------------
    logic       ferr_r, perr_r, ovf_r;
    logic [7:0] status_s;

    // Sticky flags; a set in the same cycle as a status-read clear wins.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            ferr_r <= 1'b0;
            perr_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            ferr_r <= ferr_set_s | (ferr_r & ~st_clr_s);
            perr_r <= perr_set_s | (perr_r & ~st_clr_s);
            ovf_r  <= ovf_set_s  | (ovf_r  & ~st_clr_s);
        end
    end

    assign status_s = {3'b000, ferr_r, perr_r, ovf_r, full_s, ~empty_s};

    // Read data register, refreshed every cycle from the selected source.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            DOUT <= 8'h00;
        end else if (ADDR) begin
            DOUT <= status_s;
        end else if (empty_s) begin
            DOUT <= 8'h00;
        end else begin
            DOUT <= mem_r[rd_ptr_r];
        end
    end

    assign DOE = ~CS_N & ~RD_N;
    assign IRQ = ~empty_s;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: vector table, directed corner cases
// and randomized traffic against a queue-based reference model.
module tb_ps2_rx_fifo;

    localparam int DEPTH = 8;

    logic       CLK;
    logic       RST;
    logic       KB_CLK;
    logic       KB_DATA;
    logic       CS_N;
    logic       RD_N;
    logic       ADDR;
    logic [7:0] DOUT;
    logic       DOE;
    logic       IRQ;

    int checks   = 0;
    int failures = 0;

    ps2_rx_fifo #(
        .FIFO_DEPTH    (DEPTH),
        .SAMPLE_DELAY  (8),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .KB_CLK (KB_CLK),
        .KB_DATA(KB_DATA),
        .CS_N   (CS_N),
        .RD_N   (RD_N),
        .ADDR   (ADDR),
        .DOUT   (DOUT),
        .DOE    (DOE),
        .IRQ    (IRQ)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] data;
        logic       par_flip;
        logic       stop;
        logic [7:0] exp_status;
        logic [7:0] exp_data;
    } vec_t;

    // Reference model state
    logic [7:0] mq[$];
    logic       m_ferr, m_perr, m_ovf;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%02h required=%02h", nm, act, exp);
        end
    endtask

    // Sends the first nbits bits of an 11-bit PS/2 frame. With pop_at_stop,
    // the CPU strobe (already asserted) is released 8 cycles after the stop
    // bit's KB_CLK fall so the pop lands on the same edge as the push.
    task automatic send_frame(input logic [7:0] d, input logic par_flip,
                              input logic stop_bit, input int nbits,
                              input logic pop_at_stop);
        logic [10:0] bits;
        bits = {stop_bit, (~^d) ^ par_flip, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge CLK);
            KB_DATA = bits[i];
            repeat (10) @(negedge CLK);
            KB_CLK = 1'b0;
            if (i == 10 && pop_at_stop) begin
                repeat (8) @(negedge CLK);
                CS_N = 1'b1;
                RD_N = 1'b1;
                repeat (12) @(negedge CLK);
            end else begin
                repeat (20) @(negedge CLK);
            end
            KB_CLK = 1'b1;
            repeat (10) @(negedge CLK);
        end
        KB_DATA = 1'b1;
        repeat (10) @(negedge CLK);
    endtask

    task automatic cpu_read(input logic a, output logic [7:0] v);
        @(negedge CLK);
        ADDR = a;
        CS_N = 1'b0;
        RD_N = 1'b0;
        repeat (4) @(negedge CLK);
        v = DOUT;
        CS_N = 1'b1;
        RD_N = 1'b1;
        repeat (6) @(negedge CLK);
    endtask

    function automatic logic [7:0] model_status();
        model_status = {3'b000, m_ferr, m_perr, m_ovf,
                        (mq.size() == DEPTH), (mq.size() != 0)};
    endfunction

    vec_t       vecs[6];
    logic [7:0] v;
    logic [7:0] d;
    logic [7:0] exp;
    logic       pf, sb;
    int         op, kind;

    initial begin
        vecs[0] = '{8'h1C, 1'b0, 1'b1, 8'h01, 8'h1C};
        vecs[1] = '{8'h1C, 1'b1, 1'b1, 8'h08, 8'h00};
        vecs[2] = '{8'hA5, 1'b0, 1'b0, 8'h10, 8'h00};
        vecs[3] = '{8'hFF, 1'b0, 1'b1, 8'h01, 8'hFF};
        vecs[4] = '{8'h00, 1'b1, 1'b0, 8'h18, 8'h00};
        vecs[5] = '{8'h80, 1'b1, 1'b1, 8'h08, 8'h00};

        RST = 1'b0; KB_CLK = 1'b1; KB_DATA = 1'b1;
        CS_N = 1'b1; RD_N = 1'b1; ADDR = 1'b0;
        repeat (5) @(negedge CLK);
        chk("reset_dout", DOUT, 8'h00);
        chk("reset_irq", {7'd0, IRQ}, 8'h00);
        RST = 1'b1;
        repeat (5) @(negedge CLK);

        // Strobe decode
        CS_N = 1'b0;
        #1 chk("doe_cs_only", {7'd0, DOE}, 8'h00);
        RD_N = 1'b0;
        #1 chk("doe_cs_rd", {7'd0, DOE}, 8'h01);
        CS_N = 1'b1; RD_N = 1'b1;
        repeat (6) @(negedge CLK);
        cpu_read(1'b1, v); chk("reset_status", v, 8'h00);
        cpu_read(1'b0, v); chk("reset_data_empty", v, 8'h00);

        // Vector table: one frame each from a clean, empty state
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].data, vecs[i].par_flip, vecs[i].stop, 11, 1'b0);
            chk($sformatf("vec%0d_irq", i), {7'd0, IRQ}, {7'd0, vecs[i].exp_status[0]});
            cpu_read(1'b1, v); chk($sformatf("vec%0d_status", i), v, vecs[i].exp_status);
            cpu_read(1'b0, v); chk($sformatf("vec%0d_data", i), v, vecs[i].exp_data);
            cpu_read(1'b1, v); chk($sformatf("vec%0d_status2", i), v, 8'h00);
            chk($sformatf("vec%0d_irq2", i), {7'd0, IRQ}, 8'h00);
        end

        // Overflow: nine frames into an eight-deep FIFO
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1, 11, 1'b0);
        cpu_read(1'b1, v); chk("ovf_status", v, 8'h07);
        for (int i = 1; i <= 8; i++) begin
            cpu_read(1'b0, v); chk($sformatf("ovf_data%0d", i), v, 8'(i));
        end
        cpu_read(1'b0, v); chk("ovf_data_empty", v, 8'h00);
        cpu_read(1'b1, v); chk("ovf_status_after", v, 8'h00);

        // Timeout after four data bits
        send_frame(8'h0F, 1'b0, 1'b1, 5, 1'b0);
        cpu_read(1'b1, v); chk("to_early_status", v, 8'h00);
        repeat (50) @(negedge CLK);
        cpu_read(1'b1, v); chk("to_status", v, 8'h10);
        cpu_read(1'b1, v); chk("to_status_clr", v, 8'h00);
        send_frame(8'h5A, 1'b0, 1'b1, 11, 1'b0);
        cpu_read(1'b1, v); chk("to_next_status", v, 8'h01);
        cpu_read(1'b0, v); chk("to_next_data", v, 8'h5A);

        // Reset mid-frame, then a short KB_CLK glitch, then a good frame
        send_frame(8'h77, 1'b0, 1'b1, 4, 1'b0);
        @(negedge CLK);
        RST = 1'b0;
        ADDR = 1'b1;
        repeat (3) @(negedge CLK);
        chk("midrst_dout", DOUT, 8'h00);
        RST = 1'b1;
        repeat (5) @(negedge CLK);
        KB_DATA = 1'b0;
        KB_CLK = 1'b0;
        repeat (3) @(negedge CLK);
        KB_CLK = 1'b1;
        KB_DATA = 1'b1;
        repeat (100) @(negedge CLK);
        send_frame(8'h29, 1'b0, 1'b1, 11, 1'b0);
        cpu_read(1'b1, v); chk("midrst_status", v, 8'h01);
        cpu_read(1'b0, v); chk("midrst_data", v, 8'h29);
        cpu_read(1'b1, v); chk("midrst_status2", v, 8'h00);

        // Full FIFO: data-read end coincides with a push
        for (int i = 0; i < 8; i++) send_frame(8'h31 + 8'(i), 1'b0, 1'b1, 11, 1'b0);
        @(negedge CLK);
        ADDR = 1'b0; CS_N = 1'b0; RD_N = 1'b0;
        repeat (4) @(negedge CLK);
        chk("simul_head", DOUT, 8'h31);
        send_frame(8'h40, 1'b0, 1'b1, 11, 1'b1);
        cpu_read(1'b1, v); chk("simul_status", v, 8'h03);
        for (int i = 0; i < 7; i++) begin
            cpu_read(1'b0, v); chk($sformatf("simul_data%0d", i), v, 8'h32 + 8'(i));
        end
        cpu_read(1'b0, v); chk("simul_new", v, 8'h40);
        cpu_read(1'b0, v); chk("simul_empty", v, 8'h00);

        // Randomized traffic against the reference model
        mq.delete(); m_ferr = 1'b0; m_perr = 1'b0; m_ovf = 1'b0;
        for (int n = 0; n < 36; n++) begin
            op = $urandom_range(0, 5);
            if (op <= 2) begin
                d    = 8'($urandom);
                kind = $urandom_range(0, 9);
                pf   = (kind == 0 || kind == 2);
                sb   = !(kind == 1 || kind == 2);
                send_frame(d, pf, sb, 11, 1'b0);
                if (!sb) m_ferr = 1'b1;
                if (pf)  m_perr = 1'b1;
                if (sb && !pf) begin
                    if (mq.size() < DEPTH) mq.push_back(d);
                    else m_ovf = 1'b1;
                end
            end else if (op == 3) begin
                exp = (mq.size() != 0) ? mq.pop_front() : 8'h00;
                cpu_read(1'b0, v); chk($sformatf("rnd%0d_data", n), v, exp);
            end else begin
                exp = model_status();
                m_ferr = 1'b0; m_perr = 1'b0; m_ovf = 1'b0;
                cpu_read(1'b1, v); chk($sformatf("rnd%0d_status", n), v, exp);
            end
            chk($sformatf("rnd%0d_irq", n), {7'd0, IRQ}, {7'd0, (mq.size() != 0)});
        end
        exp = model_status();
        m_ferr = 1'b0; m_perr = 1'b0; m_ovf = 1'b0;
        cpu_read(1'b1, v); chk("rnd_final_status", v, exp);
        for (int i = 0; i <= DEPTH; i++) begin
            exp = (mq.size() != 0) ? mq.pop_front() : 8'h00;
            cpu_read(1'b0, v); chk($sformatf("rnd_drain%0d", i), v, exp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
